priority_encoder_q: RTL

Queued, parametrised priority encoder. It accumulates one-hot or multi-hot request vectors into a pending register and emits the index of one pending request per handshake, highest priority first. Each emitted bit is cleared from the pending register. It is the sequential successor of the fixed 4-to-2 and 8-to-3 encoders and serves interrupt, arbitration and event-drain paths where several requests may be outstanding at once.

---
 rtl/priority_encoder_q.sv | 103 ++++++++++
 1 files changed

// File: rtl/priority_encoder_q.sv
// Queued priority encoder: accumulates request vectors into a pending register and
// emits one index per handshake. Define ROUND_ROBIN_EN for rotating priority.
module priority_encoder_q #(
  parameter  int WIDTH = 8,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] req_i,
  input  logic             req_valid_i,
  input  logic             flush_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             idx_valid_o,
  input  logic             idx_ready_i,
  output logic [WIDTH-1:0] pending_o,
  output logic             busy_o
);

  logic [WIDTH-1:0] pend_q, pend_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             idx_valid_q, idx_valid_d;
  logic [IDX_W-1:0] sel_idx;
  logic [WIDTH-1:0] grant_mask;
  logic             slot_free;
  logic             load;

`ifdef ROUND_ROBIN_EN
  logic [IDX_W-1:0] ptr_q, ptr_d;

  // Rank is the descending distance from ptr with wrap; rank 0 (ptr itself) wins.
  always_comb begin
    int best;
    int rank;
    best    = WIDTH;
    rank    = 0;
    sel_idx = '0;
    for (int k = 0; k < WIDTH; k++) begin
      rank = (int'(ptr_q) >= k) ? int'(ptr_q) - k : int'(ptr_q) - k + WIDTH;
      if (pend_q[k] && (rank < best)) begin
        best    = rank;
        sel_idx = IDX_W'(k);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (load) begin
      ptr_d = (sel_idx == '0) ? IDX_W'(WIDTH - 1) : sel_idx - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= IDX_W'(WIDTH - 1);
    else        ptr_q <= ptr_d;
  end
`else
  always_comb begin
    sel_idx = '0;
    for (int k = 0; k < WIDTH; k++) begin
      if (pend_q[k]) sel_idx = IDX_W'(k);
    end
  end
`endif

  assign slot_free = !idx_valid_q || idx_ready_i;
  assign load      = slot_free && (|pend_q) && !flush_i;

  // A bit granted and re-requested in the same cycle survives the clear.
  always_comb begin
    grant_mask  = load ? (WIDTH'(1) << sel_idx) : '0;
    pend_d      = (pend_q & ~grant_mask) | (req_valid_i ? req_i : '0);
    idx_d       = idx_q;
    idx_valid_d = idx_valid_q;
    if (flush_i) begin
      pend_d      = '0;
      idx_valid_d = 1'b0;
    end else if (load) begin
      idx_d       = sel_idx;
      idx_valid_d = 1'b1;
    end else if (slot_free) begin
      idx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q      <= '0;
      idx_q       <= '0;
      idx_valid_q <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      idx_q       <= idx_d;
      idx_valid_q <= idx_valid_d;
    end
  end

  assign idx_o       = idx_q;
  assign idx_valid_o = idx_valid_q;
  assign pending_o   = pend_q;
  assign busy_o      = (|pend_q) || idx_valid_q;

endmodule
